// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions used by the receiver (and the matching transmitter).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clock cycles per bit, truncated toward zero.
    function automatic int bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous RX line into the clk domain and filters single-cycle glitches.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxs,
    output logic rxv,
    output logic fall
);

    logic rx_meta;
    logic rxs_d1;
    logic rxs_d2;

    // Everything resets to the idle-high line level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d1  <= 1'b1;
            rxs_d2  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d1  <= rxs;
            rxs_d2  <= rxs_d1;
        end
    end

    assign rxv  = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
    assign fall = rxs_d1 & ~rxs;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, LSB-first data sampling, stop-bit check,
// one-cycle valid / framing-error pulses with registered outputs.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int HALF    = BPS_CNT / 2;

    localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    if (BPS_CNT < 16 || BPS_CNT >= 65536) begin : g_bad_cfg
        $fatal(1, "uart_rx: BPS_CNT=%0d outside 16..65535", BPS_CNT);
    end

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;

    logic rxs;
    logic rxv;
    logic fall;
    logic half_tick;
    logic bit_tick;
    logic valid_nxt;
    logic err_nxt;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (RX),
        .rxs  (rxs),
        .rxv  (rxv),
        .fall (fall)
    );

    assign half_tick = (clk_cnt == HALF_LAST);
    assign bit_tick  = (clk_cnt == BPS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only a genuine 1->0 edge arms the receiver, so a line held low (break) stays in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall && !rxs)                   state_nxt = START;
            START:   if (half_tick)                      state_nxt = rxv ? IDLE : DATA;
            DATA:    if (bit_tick && bit_cnt == LAST_BIT) state_nxt = STOP;
            STOP:    if (bit_tick)                       state_nxt = IDLE;
            default:                                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (state == STOP && bit_tick) begin
            valid_nxt = rxv;
            err_nxt   = ~rxv;
        end
    end

    // Leaving STOP at the stop-bit centre is what lets a back-to-back start edge be caught.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
                START: begin
                    clk_cnt <= half_tick ? 16'd0 : clk_cnt + 16'd1;
                    bit_cnt <= '0;
                end
                DATA: begin
                    clk_cnt <= bit_tick ? 16'd0 : clk_cnt + 16'd1;
                    if (bit_tick) begin
                        shreg   <= {rxv, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                STOP: begin
                    clk_cnt <= bit_tick ? 16'd0 : clk_cnt + 16'd1;
                end
                default: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
            rx_valid     <= valid_nxt;
            rx_frame_err <= err_nxt;
            rx_busy      <= (state_nxt != IDLE);
            if (valid_nxt) begin
                rx_data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BPS_CNT=16: drives 8N1 frames and checks each pulse on arrival.
module tb_uart_rx;

    localparam int BPS     = 16;
    localparam int LATENCY = 154;
    localparam int LAT_TOL = 3;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         fall_cycle;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    exp_t       sb[$];
    int         checks;
    int         failures;
    int         cycle;
    logic [7:0] last_good;
    logic       prev_pulse;

    uart_rx #(
        .CLK_FREQ (1600),
        .UART_BPS (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RX           (RX),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // Drives one frame starting at the current negedge; abort_bit >= 0 stops mid-way through that bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input int glitch_bit = -1, input int abort_bit = -1);
        exp_t e;
        RX = 1'b0;
        if (abort_bit < 0) begin
            if (stop_val) last_good = data;
            e.is_err     = ~stop_val;
            e.data       = last_good;
            e.fall_cycle = cycle;
            sb.push_back(e);
        end
        repeat (BPS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = data[i];
            if (i == abort_bit) begin
                repeat (BPS / 2) @(negedge clk);
                return;
            end
            if (i == glitch_bit) begin
                repeat (BPS / 2) @(negedge clk);
                RX = ~data[i];
                @(negedge clk);
                RX = data[i];
                repeat (BPS / 2 - 1) @(negedge clk);
            end else begin
                repeat (BPS) @(negedge clk);
            end
        end
        RX = stop_val;
        repeat (BPS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Every pulse must match the head of the scoreboard in kind, data and latency.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid || rx_frame_err) begin
                exp_t e;
                int   lat;
                checkOutput("pulse_expected", (sb.size() > 0), 1);
                checkOutput("valid_and_err_exclusive", (rx_valid && rx_frame_err), 0);
                checkOutput("no_back_to_back_pulse", prev_pulse, 0);
                if (sb.size() > 0) begin
                    e   = sb.pop_front();
                    lat = cycle - e.fall_cycle;
                    checkOutput("pulse_kind_err", rx_frame_err, e.is_err);
                    checkOutput("rx_data", rx_data, e.data);
                    checkOutput("latency_in_window",
                                (lat >= LATENCY - LAT_TOL && lat <= LATENCY + LAT_TOL), 1);
                end
            end
            prev_pulse <= rx_valid || rx_frame_err;
        end else begin
            prev_pulse <= 1'b0;
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        cycle      = 0;
        last_good  = 8'h00;
        prev_pulse = 1'b0;
        RX         = 1'b1;
        rst        = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_rx_frame_err", rx_frame_err, 0);
        checkOutput("reset_rx_busy", rx_busy, 0);
        rst = 1'b0;
        idle(40);

        applyStimulus(8'hA5, 1'b1);
        idle(40);

        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        idle(40);

        // Short low glitch: busy while the start bit is checked, then back to idle without a pulse.
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("glitch_busy_during_start", rx_busy, 1);
        repeat (20) @(negedge clk);
        checkOutput("glitch_busy_cleared", rx_busy, 0);
        idle(20);
        applyStimulus(8'h3C, 1'b1);
        idle(40);

        applyStimulus(8'h55, 1'b0);
        idle(40);
        checkOutput("frame_err_keeps_data", rx_data, last_good);

        applyStimulus(8'h00, 1'b1, 3);
        idle(40);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b1);
        end
        idle(40);

        // Reset in the middle of bit 4 of 0x81: partial byte must vanish without a pulse.
        applyStimulus(8'h81, 1'b1, -1, 4);
        rst = 1'b1;
        RX  = 1'b1;
        @(negedge clk);
        checkOutput("midframe_reset_rx_data", rx_data, 8'h00);
        checkOutput("midframe_reset_rx_valid", rx_valid, 0);
        checkOutput("midframe_reset_rx_frame_err", rx_frame_err, 0);
        checkOutput("midframe_reset_rx_busy", rx_busy, 0);
        last_good = 8'h00;
        rst = 1'b0;
        idle(3 * BPS);
        checkOutput("post_reset_idle_busy", rx_busy, 0);
        applyStimulus(8'h42, 1'b1);
        idle(40);

        for (int t = 0; t < 400 && sb.size() > 0; t++) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        checkOutput("final_rx_data", rx_data, 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
